buffer_fifo: RTL

Parametrised synchronous FIFO that replaces the single-entry router buffer in the ring NoC datapath. It holds up to DEPTH flits of WIDTH bits, with the same write-enable/read-enable interface and registered read data. It adds an occupancy count, an almost-full flag for credit/backpressure logic, and a read-valid strobe. One instance sits on each input port and each direction (CW/CCW) of a ring router.

---
 rtl/buffer_fifo.sv | 130 +++++++++++++
 1 files changed

// File: rtl/buffer_fifo.sv
// buffer_fifo: parametrised synchronous flit FIFO for ring-router input ports (CW/CCW).
// Latency: 1 cycle from an accepted rdEnable to dataOut/dataValid; a write is readable the cycle after it lands.
// Backpressure: full/almostFull are registered from next-state count; a refused write or an empty read is dropped.
//
// Ports:
//   clk, reset (synchronous, active-low)      - clocking and reset
//   wrEnable, dataIn                          - write request and data
//   rdEnable, dataOut, dataValid              - read request, registered read data, one-cycle valid strobe
//   full, empty, almostFull, count            - registered occupancy status
//   overflow, underflow                       - sticky error flags, present only with BUFFER_FIFO_ERR_FLAGS_EN
//
// Optional macro: BUFFER_FIFO_ERR_FLAGS_EN adds the sticky overflow/underflow outputs.
module buffer_fifo #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrEnable,
    input  logic             rdEnable,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             dataValid,
    output logic             full,
    output logic             empty,
    output logic             almostFull,
    output logic [CNT_W-1:0] count
`ifdef BUFFER_FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_vld;
    logic             r_full;
    logic             r_empty;
    logic             r_almost_full;

    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [PTR_W-1:0] w_wr_ptr_inc;
    logic [PTR_W-1:0] w_rd_ptr_inc;

    // A write into a full FIFO is still taken when a read frees the oldest slot in the same cycle.
    assign w_rd_acc     = rdEnable & ~r_empty;
    assign w_wr_acc     = wrEnable & (~r_full | rdEnable);
    assign w_cnt_nxt    = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);
    // Explicit wrap keeps non-power-of-two depths correct.
    assign w_wr_ptr_inc = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_inc = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

    // Storage is never cleared; reset only blocks the write in the reset cycle.
    always_ff @(posedge clk) begin
        if (reset && w_wr_acc) begin
            r_mem[r_wr_ptr] <= dataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_data_out    <= '0;
            r_data_vld    <= 1'b0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almost_full <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= w_rd_ptr_inc;
            end
            r_data_vld    <= w_rd_acc;
            r_count       <= w_cnt_nxt;
            // Flags decode the next count so they line up with the registered count.
            r_full        <= (w_cnt_nxt == CNT_FULL);
            r_empty       <= (w_cnt_nxt == '0);
            r_almost_full <= (w_cnt_nxt >= CNT_AF);
        end
    end

    assign dataOut    = r_data_out;
    assign dataValid  = r_data_vld;
    assign full       = r_full;
    assign empty      = r_empty;
    assign almostFull = r_almost_full;
    assign count      = r_count;

`ifdef BUFFER_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky until reset so software/debug can see a lost flit or a bogus read after the fact.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wrEnable && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (rdEnable && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule
